axi_master_and_slave: RTL and testbench
=======================================

// Module: axi_master_and_slave
// PURPOSE
//  AXI4 register slave that also owns an AXI4 master port: software programs address/data, then
//  kicks one single-beat 32-bit read or write on the master port. Sits in the block design
//  between the host interconnect (slave side, base 0xEC00_0000) and downstream memory/peripheral.
//  The slave side is a 4-register window; the master side issues one transaction at a time.
// PARAMETERS
//  S_ID_WIDTH    1   AXI ID width on slave port; IDs are echoed on B/R.
//  M_ADDR_WIDTH  32  master port address width; ADDR register is truncated to this width.
// PORTS
//  aclk              in   1    single clock for both ports
//  areset            in   1    synchronous, active-high reset
//  s_axi_aw{id,addr[31:0],len[7:0],size[2:0],burst[1:0],valid} in; s_axi_awready out
//  s_axi_w{data[31:0],strb[3:0],last,valid} in; s_axi_wready out
//  s_axi_b{id,resp[1:0],valid} out; s_axi_bready in
//  s_axi_ar{id,addr[31:0],len[7:0],size[2:0],burst[1:0],valid} in; s_axi_arready out
//  s_axi_r{id,data[31:0],resp[1:0],last,valid} out; s_axi_rready in
//  s_axi_{aw,ar}{lock,cache,prot,qos,region} in   ignored
//  m_axi_aw{addr,len,size,burst,cache,prot,lock,qos,valid} out; m_axi_awready in
//  m_axi_w{data[31:0],strb[3:0],last,valid} out; m_axi_wready in
//  m_axi_b{resp[1:0],valid} in; m_axi_bready out
//  m_axi_ar{addr,len,size,burst,cache,prot,lock,qos,valid} out; m_axi_arready in
//  m_axi_r{data[31:0],resp[1:0],last,valid} in; m_axi_rready out
// BEHAVIOUR
//  Registers (decode addr[3:2], upper bits ignored, reset 0):
//   0x0 CTRL  bit0 GO (write-1 pulse, reads 0), bit1 DIR (1=read,0=write) RW; other bits read 0.
//   0x4 ADDR  RW 32b, master target address.   0x8 DATA  RW 32b, write data / captured read data.
//   0xC STAT  RO bit0 BUSY, bit1 DONE (sticky, W1C), bits[3:2] last master RESP; others 0.
//  Slave write: AWREADY=1 when idle; accept AW, then WREADY=1 per beat; WSTRB applied per byte;
//   INCR advances register index per beat mod 4, FIXED holds it; after WLAST beat BVALID=1,
//   BRESP=OKAY, BID=AWID, held until BREADY; then AWREADY returns. One write outstanding.
//  Slave read: ARREADY=1 when idle; after accept, RVALID beats len+1, RLAST on final, RRESP=OKAY,
//   RID=ARID, data sampled the cycle the beat is presented; held until RREADY. Read/write paths
//   independent and may run concurrently.
//  Master FSM: IDLE -> (GO, DIR=0) WR: AWVALID+WVALID together, each dropped after own handshake
//   -> WB: BREADY=1 until BVALID -> IDLE. IDLE -> (GO, DIR=1) RA: ARVALID until ARREADY -> RD:
//   RREADY=1 until RVALID&RLAST; DATA<=RDATA -> IDLE. On return to IDLE: DONE=1, RESP latched.
//  Master attributes fixed: LEN=0, SIZE=3'b010, BURST=INCR, CACHE=4'b0011, PROT=0, LOCK=0,
//   QOS=0, WSTRB=4'hF, WLAST=1. ADDR/DATA/DIR sampled on the GO cycle.
//  BUSY=1 in every state except IDLE. GO while BUSY: ignored. DONE cleared by W1C write; a
//   set and clear in the same cycle -> set wins. Read capture and slave write to DATA in the
//   same cycle -> capture wins. CTRL write with GO and DIR: new DIR used for that launch.
//  Reset (any time, incl. mid-transaction): all VALID/READY outputs 0 in reset, all registers 0,
//   FSMs to IDLE; first cycle after reset AWREADY=ARREADY=1. No recovery of abandoned bursts.
// STRUCTURE
//  Package axi_ms_pkg: register offsets, CTRL/STAT bit indices, AXI burst/size/resp constants,
//   master FSM state enum.
//  Sub-module axi_ms_master_engine: the master FSM and m_axi_* channels; top holds slave logic
//   and register file.
// TESTING
//  Reset then read 0x0,0x4,0x8,0xC single-beat -> all return 0x0000_0000, RRESP=OKAY, RLAST=1.
//  Write 0xFFFF_FFFF to 0x0 -> master AR at 0x0 LEN=0 SIZE=4B; respond 0xA5A5_0001 OKAY ->
//   DATA reads 0xA5A5_0001, STAT reads 0x2.
//  Write ADDR=0x1000, DATA=0x1234_5678, CTRL=0x1 -> master AW addr 0x1000, W 0x1234_5678
//   strb F last 1; BRESP=SLVERR -> STAT=0xA; write 0x2 to STAT -> STAT=0x8.
//  GO issued while master stalled (AWREADY held 0) -> second GO ignored, exactly one AW seen.
//  4-beat INCR write at 0x4 with strb 0x3 on beat0 -> ADDR[15:0],DATA,STAT unchanged... CTRL
//   beat wraps to 0x0; single BVALID after beat 4.
//  Assert areset during master WB state -> all valids 0, STAT=0, next AW accepted normally.

Source files
------------

// File: rtl/axi_ms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_ms_pkg
// Brief    : Shared constants for the AXI register slave / single-beat master:
//            register offsets, CTRL/STAT bit positions, AXI encodings and the
//            state encodings of the slave and master state machines.
// Revision : 1.0  initial release
// ============================================================================
package axi_ms_pkg;

    // Register window, decoded from address bits [3:2]
    localparam logic [1:0] c_reg_ctrl = 2'd0;
    localparam logic [1:0] c_reg_addr = 2'd1;
    localparam logic [1:0] c_reg_data = 2'd2;
    localparam logic [1:0] c_reg_stat = 2'd3;

    // CTRL / STAT bit positions
    localparam int c_ctrl_go_bit   = 0;
    localparam int c_ctrl_dir_bit  = 1;
    localparam int c_stat_busy_bit = 0;
    localparam int c_stat_done_bit = 1;
    localparam int c_stat_resp_lsb = 2;

    // AXI encodings
    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_burst_incr  = 2'b01;
    localparam logic [2:0] c_size_4b     = 3'b010;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [3:0] c_cache_bufmod = 4'b0011;

    // Master engine states
    localparam logic [2:0] c_m_idle = 3'd0;
    localparam logic [2:0] c_m_wr   = 3'd1;
    localparam logic [2:0] c_m_wb   = 3'd2;
    localparam logic [2:0] c_m_ra   = 3'd3;
    localparam logic [2:0] c_m_rd   = 3'd4;

    // Slave write channel states
    localparam logic [1:0] c_sw_idle = 2'd0;
    localparam logic [1:0] c_sw_data = 2'd1;
    localparam logic [1:0] c_sw_resp = 2'd2;

    // Slave read channel states
    localparam logic [0:0] c_sr_idle = 1'b0;
    localparam logic [0:0] c_sr_data = 1'b1;

    // Merge new data into an old word under a byte-strobe mask
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage : axi_ms_pkg
`default_nettype wire

// File: rtl/axi_ms_master_engine.sv
`default_nettype none
// ============================================================================
// Module   : axi_ms_master_engine
// Brief    : One-at-a-time, single-beat 32-bit AXI4 master. A GO pulse in
//            IDLE launches a write (AW+W, then B) or a read (AR, then R).
//            Completion is reported as a one-cycle done pulse with the response.
// Revision : 1.0  initial release
// ============================================================================
module axi_ms_master_engine
    import axi_ms_pkg::*;
#(
    parameter int M_ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // launch request from the register file
    input  logic                    i_go,
    input  logic                    i_dir,
    input  logic [31:0]             i_addr,
    input  logic [31:0]             i_wdata,
    // status back to the register file
    output logic                    o_busy,
    output logic                    o_done,
    output logic [1:0]              o_resp,
    output logic                    o_rd_valid,
    output logic [31:0]             o_rd_data,
    // AXI4 master write address
    output logic [M_ADDR_WIDTH-1:0] o_m_axi_awaddr,
    output logic [7:0]              o_m_axi_awlen,
    output logic [2:0]              o_m_axi_awsize,
    output logic [1:0]              o_m_axi_awburst,
    output logic [3:0]              o_m_axi_awcache,
    output logic [2:0]              o_m_axi_awprot,
    output logic                    o_m_axi_awlock,
    output logic [3:0]              o_m_axi_awqos,
    output logic                    o_m_axi_awvalid,
    input  logic                    i_m_axi_awready,
    // AXI4 master write data
    output logic [31:0]             o_m_axi_wdata,
    output logic [3:0]              o_m_axi_wstrb,
    output logic                    o_m_axi_wlast,
    output logic                    o_m_axi_wvalid,
    input  logic                    i_m_axi_wready,
    // AXI4 master write response
    input  logic [1:0]              i_m_axi_bresp,
    input  logic                    i_m_axi_bvalid,
    output logic                    o_m_axi_bready,
    // AXI4 master read address
    output logic [M_ADDR_WIDTH-1:0] o_m_axi_araddr,
    output logic [7:0]              o_m_axi_arlen,
    output logic [2:0]              o_m_axi_arsize,
    output logic [1:0]              o_m_axi_arburst,
    output logic [3:0]              o_m_axi_arcache,
    output logic [2:0]              o_m_axi_arprot,
    output logic                    o_m_axi_arlock,
    output logic [3:0]              o_m_axi_arqos,
    output logic                    o_m_axi_arvalid,
    input  logic                    i_m_axi_arready,
    // AXI4 master read data
    input  logic [31:0]             i_m_axi_rdata,
    input  logic [1:0]              i_m_axi_rresp,
    input  logic                    i_m_axi_rlast,
    input  logic                    i_m_axi_rvalid,
    output logic                    o_m_axi_rready
);

    logic [2:0]              r_state;
    logic [M_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]             r_wdata;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_arvalid;
    logic                    w_aw_clear;
    logic                    w_w_clear;

    // AW and W retire independently; the write phase ends once both have
    assign w_aw_clear = ~r_awvalid | i_m_axi_awready;
    assign w_w_clear  = ~r_wvalid  | i_m_axi_wready;

    // Master state machine and launch-time capture of address/data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_m_idle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                c_m_idle: begin
                    if (i_go) begin
                        r_addr  <= i_addr[M_ADDR_WIDTH-1:0];
                        r_wdata <= i_wdata;
                        if (i_dir) begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_m_ra;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_m_wr;
                        end
                    end
                end
                c_m_wr: begin
                    if (i_m_axi_awready) r_awvalid <= 1'b0;
                    if (i_m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_clear && w_w_clear) r_state <= c_m_wb;
                end
                c_m_wb: begin
                    if (i_m_axi_bvalid) r_state <= c_m_idle;
                end
                c_m_ra: begin
                    if (i_m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= c_m_rd;
                    end
                end
                c_m_rd: begin
                    if (i_m_axi_rvalid && i_m_axi_rlast) r_state <= c_m_idle;
                end
                default: r_state <= c_m_idle;
            endcase
        end
    end

    // Status and completion reporting
    assign o_busy     = (r_state != c_m_idle);
    assign o_rd_valid = (r_state == c_m_rd) & i_m_axi_rvalid & i_m_axi_rlast;
    assign o_rd_data  = i_m_axi_rdata;
    assign o_done     = ((r_state == c_m_wb) & i_m_axi_bvalid) | o_rd_valid;
    assign o_resp     = (r_state == c_m_wb) ? i_m_axi_bresp : i_m_axi_rresp;

    // Handshake outputs are forced low while reset is held
    assign o_m_axi_awvalid = r_awvalid & ~rst;
    assign o_m_axi_wvalid  = r_wvalid  & ~rst;
    assign o_m_axi_arvalid = r_arvalid & ~rst;
    assign o_m_axi_bready  = (r_state == c_m_wb) & ~rst;
    assign o_m_axi_rready  = (r_state == c_m_rd) & ~rst;

    // Fixed single-beat, 4-byte, incrementing, bufferable/modifiable attributes
    assign o_m_axi_awaddr  = r_addr;
    assign o_m_axi_awlen   = 8'd0;
    assign o_m_axi_awsize  = c_size_4b;
    assign o_m_axi_awburst = c_burst_incr;
    assign o_m_axi_awcache = c_cache_bufmod;
    assign o_m_axi_awprot  = 3'd0;
    assign o_m_axi_awlock  = 1'b0;
    assign o_m_axi_awqos   = 4'd0;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = 4'hF;
    assign o_m_axi_wlast   = 1'b1;
    assign o_m_axi_araddr  = r_addr;
    assign o_m_axi_arlen   = 8'd0;
    assign o_m_axi_arsize  = c_size_4b;
    assign o_m_axi_arburst = c_burst_incr;
    assign o_m_axi_arcache = c_cache_bufmod;
    assign o_m_axi_arprot  = 3'd0;
    assign o_m_axi_arlock  = 1'b0;
    assign o_m_axi_arqos   = 4'd0;

endmodule : axi_ms_master_engine
`default_nettype wire

// File: rtl/axi_master_and_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_and_slave
// Brief    : AXI4 slave exposing CTRL/ADDR/DATA/STAT registers that drive a
//            single-beat AXI4 master engine. Slave write and read channels are
//            independent; one write and one read burst may be in flight.
// Revision : 1.0  initial release
// ============================================================================
module axi_master_and_slave
    import axi_ms_pkg::*;
#(
    parameter int S_ID_WIDTH   = 1,
    parameter int M_ADDR_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    // slave write address
    input  logic [S_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [31:0]             s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    // slave write data
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    // slave write response
    output logic [S_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // slave read address
    input  logic [S_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [31:0]             s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // slave read data
    output logic [S_ID_WIDTH-1:0]   s_axi_rid,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // master write address
    output logic [M_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // master write data
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // master write response
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // master read address
    output logic [M_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // master read data
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    // slave write channel
    logic [1:0]            r_wstate;
    logic [S_ID_WIDTH-1:0] r_bid;
    logic [1:0]            r_widx;
    logic                  r_wfixed;
    // slave read channel
    logic [0:0]            r_rstate;
    logic [S_ID_WIDTH-1:0] r_rid;
    logic [1:0]            r_ridx;
    logic                  r_rfixed;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rcnt;
    // register file
    logic                  r_dir;
    logic [31:0]           r_addr;
    logic [31:0]           r_data;
    logic                  r_done;
    logic [1:0]            r_resp;
    // engine interface
    logic                  w_busy;
    logic                  w_done;
    logic [1:0]            w_resp;
    logic                  w_rd_valid;
    logic [31:0]           w_rd_data;
    logic                  w_go;
    logic                  w_launch_dir;
    logic                  w_wr_beat;
    logic [31:0]           w_rdata;
    logic                  w_unused_ok;

    assign w_wr_beat = s_axi_wvalid & s_axi_wready;

    // GO fires on a CTRL beat with bit0 set; a DIR written in the same beat applies to this launch
    assign w_go         = w_wr_beat & (r_widx == c_reg_ctrl) & s_axi_wstrb[0] & s_axi_wdata[c_ctrl_go_bit];
    assign w_launch_dir = s_axi_wstrb[0] ? s_axi_wdata[c_ctrl_dir_bit] : r_dir;

    // Slave write channel: AW accept, per-beat register index walk, single B response
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate <= c_sw_idle;
            r_bid    <= '0;
            r_widx   <= '0;
            r_wfixed <= 1'b0;
        end else begin
            case (r_wstate)
                c_sw_idle: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        r_bid    <= s_axi_awid;
                        r_widx   <= s_axi_awaddr[3:2];
                        r_wfixed <= (s_axi_awburst == c_burst_fixed);
                        r_wstate <= c_sw_data;
                    end
                end
                c_sw_data: begin
                    if (w_wr_beat) begin
                        if (!r_wfixed) r_widx <= r_widx + 2'd1;
                        if (s_axi_wlast) r_wstate <= c_sw_resp;
                    end
                end
                c_sw_resp: begin
                    if (s_axi_bready) r_wstate <= c_sw_idle;
                end
                default: r_wstate <= c_sw_idle;
            endcase
        end
    end

    // Slave read channel: AR accept, then len+1 beats walking the register index
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rstate <= c_sr_idle;
            r_rid    <= '0;
            r_ridx   <= '0;
            r_rfixed <= 1'b0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
        end else begin
            case (r_rstate)
                c_sr_idle: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_rid    <= s_axi_arid;
                        r_ridx   <= s_axi_araddr[3:2];
                        r_rfixed <= (s_axi_arburst == c_burst_fixed);
                        r_rlen   <= s_axi_arlen;
                        r_rcnt   <= '0;
                        r_rstate <= c_sr_data;
                    end
                end
                default: begin
                    if (s_axi_rready) begin
                        if (r_rcnt == r_rlen) begin
                            r_rstate <= c_sr_idle;
                        end else begin
                            r_rcnt <= r_rcnt + 8'd1;
                            if (!r_rfixed) r_ridx <= r_ridx + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Register file; master completion has priority over software writes to DATA/DONE
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_dir  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_done <= 1'b0;
            r_resp <= '0;
        end else begin
            if (w_wr_beat && (r_widx == c_reg_ctrl) && s_axi_wstrb[0]) begin
                r_dir <= s_axi_wdata[c_ctrl_dir_bit];
            end
            if (w_wr_beat && (r_widx == c_reg_addr)) begin
                r_addr <= apply_strb(r_addr, s_axi_wdata, s_axi_wstrb);
            end
            if (w_rd_valid) begin
                r_data <= w_rd_data;
            end else if (w_wr_beat && (r_widx == c_reg_data)) begin
                r_data <= apply_strb(r_data, s_axi_wdata, s_axi_wstrb);
            end
            if (w_done) begin
                r_done <= 1'b1;
                r_resp <= w_resp;
            end else if (w_wr_beat && (r_widx == c_reg_stat) && s_axi_wstrb[0] &&
                         s_axi_wdata[c_stat_done_bit]) begin
                r_done <= 1'b0;
            end
        end
    end

    // Read-data mux, sampled live while each beat is presented
    always_comb begin
        w_rdata = '0;
        case (r_ridx)
            c_reg_ctrl: w_rdata[c_ctrl_dir_bit] = r_dir;
            c_reg_addr: w_rdata = r_addr;
            c_reg_data: w_rdata = r_data;
            default: begin
                w_rdata[c_stat_busy_bit]                    = w_busy;
                w_rdata[c_stat_done_bit]                    = r_done;
                w_rdata[c_stat_resp_lsb +: 2]               = r_resp;
            end
        endcase
    end

    assign s_axi_awready = (r_wstate == c_sw_idle) & ~areset;
    assign s_axi_wready  = (r_wstate == c_sw_data) & ~areset;
    assign s_axi_bvalid  = (r_wstate == c_sw_resp) & ~areset;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = c_resp_okay;
    assign s_axi_arready = (r_rstate == c_sr_idle) & ~areset;
    assign s_axi_rvalid  = (r_rstate == c_sr_data) & ~areset;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = w_rdata;
    assign s_axi_rresp   = c_resp_okay;
    assign s_axi_rlast   = (r_rcnt == r_rlen);

    // Attributes and address bits outside the 4-register decode carry no meaning here
    assign w_unused_ok = &{1'b0, s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_awlen, s_axi_awsize,
                           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                           s_axi_araddr[31:4], s_axi_araddr[1:0], s_axi_arsize,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

    axi_ms_master_engine #(
        .M_ADDR_WIDTH (M_ADDR_WIDTH)
    ) u_engine (
        .clk             (aclk),
        .rst             (areset),
        .i_go            (w_go),
        .i_dir           (w_launch_dir),
        .i_addr          (r_addr),
        .i_wdata         (r_data),
        .o_busy          (w_busy),
        .o_done          (w_done),
        .o_resp          (w_resp),
        .o_rd_valid      (w_rd_valid),
        .o_rd_data       (w_rd_data),
        .o_m_axi_awaddr  (m_axi_awaddr),
        .o_m_axi_awlen   (m_axi_awlen),
        .o_m_axi_awsize  (m_axi_awsize),
        .o_m_axi_awburst (m_axi_awburst),
        .o_m_axi_awcache (m_axi_awcache),
        .o_m_axi_awprot  (m_axi_awprot),
        .o_m_axi_awlock  (m_axi_awlock),
        .o_m_axi_awqos   (m_axi_awqos),
        .o_m_axi_awvalid (m_axi_awvalid),
        .i_m_axi_awready (m_axi_awready),
        .o_m_axi_wdata   (m_axi_wdata),
        .o_m_axi_wstrb   (m_axi_wstrb),
        .o_m_axi_wlast   (m_axi_wlast),
        .o_m_axi_wvalid  (m_axi_wvalid),
        .i_m_axi_wready  (m_axi_wready),
        .i_m_axi_bresp   (m_axi_bresp),
        .i_m_axi_bvalid  (m_axi_bvalid),
        .o_m_axi_bready  (m_axi_bready),
        .o_m_axi_araddr  (m_axi_araddr),
        .o_m_axi_arlen   (m_axi_arlen),
        .o_m_axi_arsize  (m_axi_arsize),
        .o_m_axi_arburst (m_axi_arburst),
        .o_m_axi_arcache (m_axi_arcache),
        .o_m_axi_arprot  (m_axi_arprot),
        .o_m_axi_arlock  (m_axi_arlock),
        .o_m_axi_arqos   (m_axi_arqos),
        .o_m_axi_arvalid (m_axi_arvalid),
        .i_m_axi_arready (m_axi_arready),
        .i_m_axi_rdata   (m_axi_rdata),
        .i_m_axi_rresp   (m_axi_rresp),
        .i_m_axi_rlast   (m_axi_rlast),
        .i_m_axi_rvalid  (m_axi_rvalid),
        .o_m_axi_rready  (m_axi_rready)
    );

endmodule : axi_master_and_slave
`default_nettype wire

// File: tb/tb_axi_master_and_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_master_and_slave
// Brief    : Directed self-checking bench: host-side register traffic on the
//            slave port, a hand-driven memory model on the master port, and a
//            scoreboard queue of expected read beats.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_master_and_slave;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [0:0]  s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
    logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, s_axi_rdata;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]  s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_awburst = 2'd1, s_axi_arburst = 2'd1, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awlock = 1'b0, s_axi_arlock = 1'b0;
    logic [3:0]  s_axi_awcache = '0, s_axi_arcache = '0, s_axi_awqos = '0, s_axi_arqos = '0;
    logic [3:0]  s_axi_awregion = '0, s_axi_arregion = '0;
    logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_awready, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0, s_axi_bvalid, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata = '0;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp = '0, m_axi_rresp = '0;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_wstrb;
    logic        m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_awready = 1'b0;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready = 1'b0, m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] wd[4];
    logic [3:0]  ws[4];
    logic [31:0] rexp[4];
    logic [0:0]  cur_id = '0;
    int          aw_seen;

    axi_master_and_slave #(.S_ID_WIDTH(1), .M_ADDR_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awregion(s_axi_awregion), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arregion(s_axi_arregion), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awlock(m_axi_awlock), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Host write burst of len+1 beats from wd/ws; expects exactly one OKAY B with the AW ID
    task automatic s_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
        cur_id        = ~cur_id;
        s_axi_awid    = cur_id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        for (int n = 0; n < 50 && !s_axi_awready; n++) @(negedge aclk);
        chk("s_awready", s_axi_awready, 1);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata  = wd[i];
            s_axi_wstrb  = ws[i];
            s_axi_wlast  = (i == len);
            s_axi_wvalid = 1'b1;
            for (int n = 0; n < 50 && !s_axi_wready; n++) @(negedge aclk);
            chk("s_wready", s_axi_wready, 1);
            @(negedge aclk);
            s_axi_wvalid = 1'b0;
            s_axi_wlast  = 1'b0;
        end
        for (int n = 0; n < 50 && !s_axi_bvalid; n++) @(negedge aclk);
        chk("s_bvalid", s_axi_bvalid, 1);
        chk("s_bresp", s_axi_bresp, 2'b00);
        chk("s_bid", s_axi_bid, cur_id);
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        chk("s_bvalid_single", s_axi_bvalid, 0);
    endtask

    task automatic s_write1(input logic [31:0] addr, input logic [31:0] data);
        wd[0] = data;
        ws[0] = 4'hF;
        s_write(addr, 0, 2'b01);
    endtask

    // Host read burst; expected beats from rexp go through the scoreboard queue
    task automatic s_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
        logic [31:0] exp_d;
        for (int i = 0; i <= len; i++) sb_q.push_back(rexp[i]);
        cur_id        = ~cur_id;
        s_axi_arid    = cur_id;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        for (int n = 0; n < 50 && !s_axi_arready; n++) @(negedge aclk);
        chk("s_arready", s_axi_arready, 1);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        for (int i = 0; i <= len; i++) begin
            for (int n = 0; n < 50 && !s_axi_rvalid; n++) @(negedge aclk);
            chk("s_rvalid", s_axi_rvalid, 1);
            exp_d = sb_q.pop_front();
            chk($sformatf("s_rdata@%0h[%0d]", addr, i), s_axi_rdata, exp_d);
            chk("s_rresp", s_axi_rresp, 2'b00);
            chk("s_rlast", s_axi_rlast, (i == len));
            chk("s_rid", s_axi_rid, cur_id);
            @(negedge aclk);
        end
        s_axi_rready = 1'b0;
    endtask

    task automatic s_read1(input logic [31:0] addr, input logic [31:0] exp_d);
        rexp[0] = exp_d;
        s_read(addr, 0, 2'b01);
    endtask

    // Memory side: accept one AW+W pair together and check the fixed attributes
    task automatic m_accept_write(input logic [31:0] addr, input logic [31:0] data);
        for (int n = 0; n < 50 && !m_axi_awvalid; n++) @(negedge aclk);
        chk("m_awvalid", m_axi_awvalid, 1);
        chk("m_wvalid", m_axi_wvalid, 1);
        chk("m_awaddr", m_axi_awaddr, addr);
        chk("m_awlen", m_axi_awlen, 0);
        chk("m_awsize", m_axi_awsize, 3'b010);
        chk("m_awburst", m_axi_awburst, 2'b01);
        chk("m_wdata", m_axi_wdata, data);
        chk("m_wstrb", m_axi_wstrb, 4'hF);
        chk("m_wlast", m_axi_wlast, 1);
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        @(negedge aclk);
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        aw_seen++;
    endtask

    task automatic m_send_b(input logic [1:0] resp);
        m_axi_bresp  = resp;
        m_axi_bvalid = 1'b1;
        for (int n = 0; n < 50 && !m_axi_bready; n++) @(negedge aclk);
        chk("m_bready", m_axi_bready, 1);
        @(negedge aclk);
        m_axi_bvalid = 1'b0;
    endtask

    task automatic m_serve_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        for (int n = 0; n < 50 && !m_axi_arvalid; n++) @(negedge aclk);
        chk("m_arvalid", m_axi_arvalid, 1);
        chk("m_araddr", m_axi_araddr, addr);
        chk("m_arlen", m_axi_arlen, 0);
        chk("m_arsize", m_axi_arsize, 3'b010);
        chk("m_arburst", m_axi_arburst, 2'b01);
        chk("m_arcache", m_axi_arcache, 4'b0011);
        m_axi_arready = 1'b1;
        @(negedge aclk);
        m_axi_arready = 1'b0;
        m_axi_rdata   = data;
        m_axi_rresp   = resp;
        m_axi_rlast   = 1'b1;
        m_axi_rvalid  = 1'b1;
        for (int n = 0; n < 50 && !m_axi_rready; n++) @(negedge aclk);
        chk("m_rready", m_axi_rready, 1);
        @(negedge aclk);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    // Directed sequence
    initial begin
        int aw_extra;
        aw_seen = 0;
        repeat (3) @(negedge aclk);
        chk("rst_awready_low", s_axi_awready, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_awready", s_axi_awready, 1);
        chk("rst_arready", s_axi_arready, 1);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_m_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);

        // all registers read zero after reset
        s_read1(32'h0, 32'h0);
        s_read1(32'h4, 32'h0);
        s_read1(32'h8, 32'h0);
        s_read1(32'hC, 32'h0);

        // GO with DIR=1 from an all-ones CTRL write: master read of address 0
        s_write1(32'h0, 32'hFFFF_FFFF);
        m_serve_read(32'h0, 32'hA5A5_0001, 2'b00);
        s_read1(32'h8, 32'hA5A5_0001);
        s_read1(32'hC, 32'h2);
        s_read1(32'h0, 32'h2);

        // master write, SLVERR response, then W1C of DONE
        s_write1(32'h4, 32'h0000_1000);
        s_write1(32'h8, 32'h1234_5678);
        s_write1(32'h0, 32'h1);
        m_accept_write(32'h1000, 32'h1234_5678);
        m_send_b(2'b10);
        s_read1(32'hC, 32'hA);
        s_write1(32'hC, 32'h2);
        s_read1(32'hC, 32'h8);

        // second GO while master is stalled on AWREADY is ignored
        aw_seen = 0;
        s_write1(32'h0, 32'h1);
        repeat (4) @(negedge aclk);
        s_read1(32'hC, 32'h9);
        s_write1(32'h0, 32'h1);
        m_accept_write(32'h1000, 32'h1234_5678);
        m_send_b(2'b00);
        aw_extra = 0;
        for (int n = 0; n < 10; n++) begin
            if (m_axi_awvalid) aw_extra++;
            @(negedge aclk);
        end
        chk("aw_count", aw_seen + aw_extra, 1);
        s_read1(32'hC, 32'h2);

        // 4-beat INCR write from ADDR wrapping to CTRL; STAT beat has no W1C bit
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'h3;
        wd[1] = 32'hCAFE_F00D; ws[1] = 4'hF;
        wd[2] = 32'h0000_0000; ws[2] = 4'hF;
        wd[3] = 32'h0000_0002; ws[3] = 4'hF;
        s_write(32'h4, 3, 2'b01);
        rexp[0] = 32'hCAFE_F00D; rexp[1] = 32'h2; rexp[2] = 32'h2; rexp[3] = 32'h0000_BEEF;
        s_read(32'h8, 3, 2'b01);
        rexp[0] = 32'h0000_BEEF; rexp[1] = 32'h0000_BEEF;
        s_read(32'hEC00_0004, 1, 2'b00);

        // reset while the master waits in the write-response state
        s_write1(32'h0, 32'h1);
        m_accept_write(32'h0000_BEEF, 32'hCAFE_F00D);
        chk("wb_bready", m_axi_bready, 1);
        areset = 1'b1;
        @(negedge aclk);
        chk("rstmid_m", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        chk("rstmid_s", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("post_awready", s_axi_awready, 1);
        chk("post_arready", s_axi_arready, 1);
        s_read1(32'hC, 32'h0);
        s_read1(32'h4, 32'h0);
        s_write1(32'h4, 32'h0000_0020);
        s_read1(32'h4, 32'h0000_0020);
        chk("post_m_awvalid", m_axi_awvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axi_master_and_slave
`default_nettype wire
